// File: rtl/writeback_buffer.sv
// Write-back queue between the ALU/load result paths and the register-file write port.
// Retires one queued write per cycle and forwards pending data to decode lookups.
module writeback_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  output logic          write_enable,
  output logic [AW-1:0] write_address,
  output logic [DW-1:0] write_data,
  input  logic [AW-1:0] addres1,
  input  logic [AW-1:0] addres2,
  output logic          pend1,
  output logic          pend2,
  output logic [DW-1:0] fwd1,
  output logic [DW-1:0] fwd2,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          mem_enq;
  logic          alu_enq;
  logic          pop;
  logic [1:0]    enq_count;

  // Credit comes from the registered count only; the pop happening this cycle is not counted.
  assign free      = CW'(DEPTH) - count;
  assign mem_ready = (free >= CW'(1));
  assign alu_ready = (free >= CW'(2)) | ((free >= CW'(1)) & ~mem_valid);
  assign empty     = (count == '0);

  // Results for register 0 complete the handshake but never occupy a slot.
  assign mem_enq   = mem_valid & mem_ready & (mem_addr != '0);
  assign alu_enq   = alu_valid & alu_ready & (alu_addr != '0);
  assign enq_count = {1'b0, mem_enq} + {1'b0, alu_enq};

  assign pop           = ~empty;
  assign write_enable  = pop;
  assign write_address = empty ? '0 : addr_q[head];
  assign write_data    = empty ? '0 : data_q[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(enq_count);
      count <= count + CW'(enq_count) - CW'(pop);
    end
  end

  // The load result takes the tail slot first so the ALU result is always the younger one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (mem_enq) begin
        addr_q[tail] <= mem_addr;
        data_q[tail] <= mem_data;
      end
      if (alu_enq) begin
        addr_q[tail + PW'(mem_enq)] <= alu_addr;
        data_q[tail + PW'(mem_enq)] <= alu_data;
      end
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    fwd1  = '0;
    fwd2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if ((addres1 != '0) && (addr_q[head + PW'(i)] == addres1)) begin
          pend1 = 1'b1;
          fwd1  = data_q[head + PW'(i)];
        end
        if ((addres2 != '0) && (addr_q[head + PW'(i)] == addres2)) begin
          pend2 = 1'b1;
          fwd2  = data_q[head + PW'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: directed scenarios plus a randomized run against a queue model.
// A second DEPTH=2 instance shares the inputs so the full condition can actually be reached.
module tb_writeback_buffer;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        mem_valid, alu_valid;
  logic [4:0]  mem_addr, alu_addr, addres1, addres2;
  logic [31:0] mem_data, alu_data;

  logic        mem_ready, alu_ready, write_enable, pend1, pend2, empty;
  logic [4:0]  write_address;
  logic [31:0] write_data, fwd1, fwd2;

  logic        s_mem_ready, s_alu_ready, s_write_enable, s_pend1, s_pend2, s_empty;
  logic [4:0]  s_write_address;
  logic [31:0] s_write_data, s_fwd1, s_fwd2;

  int checks = 0;
  int errors = 0;

  writeback_buffer #(.DEPTH(4), .DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .addres1(addres1), .addres2(addres2), .pend1(pend1), .pend2(pend2),
    .fwd1(fwd1), .fwd2(fwd2), .empty(empty)
  );

  writeback_buffer #(.DEPTH(2), .DW(32), .AW(5)) dut_small (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(s_mem_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(s_alu_ready),
    .write_enable(s_write_enable), .write_address(s_write_address), .write_data(s_write_data),
    .addres1(addres1), .addres2(addres2), .pend1(s_pend1), .pend2(s_pend2),
    .fwd1(s_fwd1), .fwd2(s_fwd2), .empty(s_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_valid = 1'b0; alu_valid = 1'b0;
    mem_addr = '0; alu_addr = '0; mem_data = '0; alu_data = '0;
    addres1 = '0; addres2 = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    addres1 = 5'd5;
    addres2 = 5'd9;
    @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", write_enable); end
    checks++; if ({write_address, write_data} !== 37'h0) begin errors++; $display("[TB] FAIL reset_wport: got %h/%h expected 0/0", write_address, write_data); end
    checks++; if ({mem_ready, alu_ready} !== 2'b11) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 11", {mem_ready, alu_ready}); end
    checks++; if ({pend1, pend2, fwd1, fwd2} !== 66'h0) begin errors++; $display("[TB] FAIL reset_lookup: got %b%b %h %h expected all 0", pend1, pend2, fwd1, fwd2); end
  endtask

  task automatic test_single_alu();
    do_reset();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h55;
    @(negedge clk);
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b expected 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    addres1 = 5'd5;
    @(negedge clk);
    checks++; if ({write_enable, write_address, write_data} !== {1'b1, 5'd5, 32'h55}) begin errors++; $display("[TB] FAIL single_write: got %b/%h/%h expected 1/05/00000055", write_enable, write_address, write_data); end
    checks++; if ({pend1, fwd1} !== {1'b1, 32'h55}) begin errors++; $display("[TB] FAIL single_fwd_head: got %b/%h expected 1/00000055", pend1, fwd1); end
    tick();
    @(negedge clk);
    checks++; if ({empty, write_enable} !== 2'b10) begin errors++; $display("[TB] FAIL single_drained: got empty=%b we=%b expected 1/0", empty, write_enable); end
  endtask

  task automatic test_dual();
    do_reset();
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'hA;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hB;
    @(negedge clk);
    checks++; if ({mem_ready, alu_ready} !== 2'b11) begin errors++; $display("[TB] FAIL dual_ready: got %b expected 11", {mem_ready, alu_ready}); end
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    addres1 = 5'd3;
    @(negedge clk);
    checks++; if ({write_enable, write_address, write_data} !== {1'b1, 5'd3, 32'hA}) begin errors++; $display("[TB] FAIL dual_first: got %b/%h/%h expected 1/03/0000000a", write_enable, write_address, write_data); end
    checks++; if ({pend1, fwd1} !== {1'b1, 32'hB}) begin errors++; $display("[TB] FAIL dual_youngest: got %b/%h expected 1/0000000b", pend1, fwd1); end
    tick();
    @(negedge clk);
    checks++; if ({write_enable, write_address, write_data} !== {1'b1, 5'd3, 32'hB}) begin errors++; $display("[TB] FAIL dual_second: got %b/%h/%h expected 1/03/0000000b", write_enable, write_address, write_data); end
    tick();
    @(negedge clk);
    checks++; if ({empty, pend1} !== 2'b10) begin errors++; $display("[TB] FAIL dual_drained: got empty=%b pend1=%b expected 1/0", empty, pend1); end
  endtask

  task automatic test_fill();
    ent_t got[$];
    ent_t exp_q[$];
    ent_t e;
    int km, ka;
    logic macc, aacc;
    do_reset();
    km = 0; ka = 0;
    for (int k = 0; k < 3; k++) begin
      e.a = 5'(1 + k);  e.d = 32'h100 + 32'(k); exp_q.push_back(e);
      e.a = 5'(10 + k); e.d = 32'h200 + 32'(k); exp_q.push_back(e);
    end
    mem_valid = 1'b1; mem_addr = 5'd1;  mem_data = 32'h100;
    alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'h200;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (write_enable === 1'b1) begin
        e.a = write_address; e.d = write_data; got.push_back(e);
      end
      if (c == 2) begin
        checks++; if ({mem_ready, alu_ready} !== 2'b10) begin errors++; $display("[TB] FAIL fill_alu_backoff: got %b expected 10", {mem_ready, alu_ready}); end
      end
      if (c == 3) begin
        checks++; if ({mem_valid, alu_ready} !== 2'b01) begin errors++; $display("[TB] FAIL fill_alu_resume: got %b expected 01", {mem_valid, alu_ready}); end
      end
      macc = mem_valid & mem_ready;
      aacc = alu_valid & alu_ready;
      tick();
      if (macc) begin
        km++;
        if (km < 3) begin mem_addr = 5'(1 + km); mem_data = 32'h100 + 32'(km); end
        else mem_valid = 1'b0;
      end
      if (aacc) begin
        ka++;
        if (ka < 3) begin alu_addr = 5'(10 + ka); alu_data = 32'h200 + 32'(ka); end
        else alu_valid = 1'b0;
      end
    end
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("[TB] FAIL fill_count: got %0d writes expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL fill_order[%0d]: got %h/%h expected %h/%h", i, got[i].a, got[i].d, exp_q[i].a, exp_q[i].d); end
    end
  endtask

  task automatic test_zero_addr();
    do_reset();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF;
    addres2 = 5'd0;
    @(negedge clk);
    checks++; if ({alu_ready, pend2} !== 2'b10) begin errors++; $display("[TB] FAIL zero_ready: got ready=%b pend2=%b expected 1/0", alu_ready, pend2); end
    tick();
    alu_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({write_enable, empty, pend2, fwd2} !== {2'b01, 33'h0}) begin errors++; $display("[TB] FAIL zero_no_write: got we=%b empty=%b pend2=%b fwd2=%h expected 0/1/0/0", write_enable, empty, pend2, fwd2); end
      tick();
    end
  endtask

  task automatic test_full();
    do_reset();
    mem_valid = 1'b1; mem_addr = 5'd1; mem_data = 32'h11;
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h22;
    @(negedge clk);
    checks++; if ({s_mem_ready, s_alu_ready} !== 2'b11) begin errors++; $display("[TB] FAIL full_start_ready: got %b expected 11", {s_mem_ready, s_alu_ready}); end
    tick();
    mem_addr = 5'd3; mem_data = 32'h33;
    alu_addr = 5'd4; alu_data = 32'h44;
    @(negedge clk);
    checks++; if ({s_mem_ready, s_alu_ready} !== 2'b00) begin errors++; $display("[TB] FAIL full_ready: got %b expected 00", {s_mem_ready, s_alu_ready}); end
    checks++; if ({s_write_enable, s_write_address, s_write_data} !== {1'b1, 5'd1, 32'h11}) begin errors++; $display("[TB] FAIL full_pop: got %b/%h/%h expected 1/01/00000011", s_write_enable, s_write_address, s_write_data); end
    tick();
    @(negedge clk);
    checks++; if ({s_mem_ready, s_alu_ready} !== 2'b10) begin errors++; $display("[TB] FAIL full_reassert: got %b expected 10", {s_mem_ready, s_alu_ready}); end
    checks++; if ({s_write_address, s_write_data} !== {5'd2, 32'h22}) begin errors++; $display("[TB] FAIL full_second: got %h/%h expected 02/00000022", s_write_address, s_write_data); end
    mem_valid = 1'b0; alu_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h77;
    alu_valid = 1'b1; alu_addr = 5'd8; alu_data = 32'h88;
    tick();
    mem_addr = 5'd9;  mem_data = 32'h99;
    alu_addr = 5'd10; alu_data = 32'hAA;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_valid = 1'b0; alu_valid = 1'b0;
    addres1 = 5'd7;
    @(negedge clk);
    checks++; if ({empty, write_enable, pend1} !== 3'b100) begin errors++; $display("[TB] FAIL midreset_state: got empty=%b we=%b pend1=%b expected 1/0/0", empty, write_enable, pend1); end
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      checks++; if (write_enable !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stale_write: got we=%b addr=%h expected we=0", write_enable, write_address); end
    end
  endtask

  task automatic test_random(input int n);
    ent_t q[$];
    ent_t e;
    int free;
    logic exp_mr, exp_ar, exp_we, exp_p1, exp_p2, macc, aacc;
    logic [4:0] exp_wa;
    logic [31:0] exp_wd, exp_f1, exp_f2;
    do_reset();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      free   = 4 - q.size();
      exp_mr = (free >= 1);
      exp_ar = (free >= 2) || ((free >= 1) && !mem_valid);
      exp_we = (q.size() != 0);
      exp_wa = exp_we ? q[0].a : 5'd0;
      exp_wd = exp_we ? q[0].d : 32'd0;
      exp_p1 = 1'b0; exp_f1 = '0; exp_p2 = 1'b0; exp_f2 = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!exp_p1 && addres1 != 0 && q[i].a == addres1) begin exp_p1 = 1'b1; exp_f1 = q[i].d; end
        if (!exp_p2 && addres2 != 0 && q[i].a == addres2) begin exp_p2 = 1'b1; exp_f2 = q[i].d; end
      end
      checks++; if ({mem_ready, alu_ready, empty} !== {exp_mr, exp_ar, !exp_we}) begin errors++; $display("[TB] FAIL rand_handshake @%0d: got %b expected %b", c, {mem_ready, alu_ready, empty}, {exp_mr, exp_ar, !exp_we}); end
      checks++; if ({write_enable, write_address, write_data} !== {exp_we, exp_wa, exp_wd}) begin errors++; $display("[TB] FAIL rand_write @%0d: got %b/%h/%h expected %b/%h/%h", c, write_enable, write_address, write_data, exp_we, exp_wa, exp_wd); end
      checks++; if ({pend1, fwd1, pend2, fwd2} !== {exp_p1, exp_f1, exp_p2, exp_f2}) begin errors++; $display("[TB] FAIL rand_lookup @%0d: got %b/%h %b/%h expected %b/%h %b/%h", c, pend1, fwd1, pend2, fwd2, exp_p1, exp_f1, exp_p2, exp_f2); end
      macc = mem_valid & exp_mr;
      aacc = alu_valid & exp_ar;
      if (reset) q.delete();
      else begin
        if (exp_we) void'(q.pop_front());
        if (macc && mem_addr != 0) begin e.a = mem_addr; e.d = mem_data; q.push_back(e); end
        if (aacc && alu_addr != 0) begin e.a = alu_addr; e.d = alu_data; q.push_back(e); end
      end
      tick();
      reset = ($urandom_range(0, 99) == 0);
      if (!mem_valid || macc) begin
        mem_valid = ($urandom_range(0, 3) != 0); mem_addr = 5'($urandom_range(0, 7)); mem_data = $urandom;
      end
      if (!alu_valid || aacc) begin
        alu_valid = ($urandom_range(0, 3) != 0); alu_addr = 5'($urandom_range(0, 7)); alu_data = $urandom;
      end
      addres1 = 5'($urandom_range(0, 7));
      addres2 = 5'($urandom_range(0, 7));
    end
    reset = 1'b0;
    mem_valid = 1'b0; alu_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mem_valid = 1'b0; alu_valid = 1'b0;
    mem_addr = '0; alu_addr = '0; mem_data = '0; alu_data = '0;
    addres1 = '0; addres2 = '0;
    test_reset();
    test_single_alu();
    test_dual();
    test_fill();
    test_zero_addr();
    test_full();
    test_reset_midstream();
    test_random(600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
